// File: rtl/multi_channel_queue.sv
// Per-channel circular FIFOs sharing one partitioned memory, with
// occupancy, hysteretic throttle, push backpressure and a drop counter.
module multi_channel_queue #(
  parameter int DATA_SIZE     = 8,
  parameter int QUEUE_LENGTH  = 4,
  parameter int CHANNELS      = 4,
  parameter int REGISTER_SIZE = 32,
  parameter int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int CNT_W = $clog2(QUEUE_LENGTH) + 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push_valid,
  input  logic [CH_W-1:0]           push_channel,
  input  logic [DATA_SIZE-1:0]      push_data,
  output logic                      push_ready,
  input  logic                      pop_valid,
  input  logic [CH_W-1:0]           pop_channel,
  output logic [DATA_SIZE-1:0]      pop_data,
  output logic                      pop_data_valid,
  output logic [CH_W-1:0]           pop_data_channel,
  output logic [CHANNELS-1:0]       empty,
  output logic [CHANNELS-1:0]       full,
  output logic [CHANNELS*CNT_W-1:0] occupancy,
  input  logic [REGISTER_SIZE-1:0]  high_threshold,
  input  logic [REGISTER_SIZE-1:0]  low_threshold,
  output logic [CHANNELS-1:0]       throttle,
  input  logic                      drop_clear,
  output logic [REGISTER_SIZE-1:0]  drop_count
);

  localparam int PTR_W = $clog2(QUEUE_LENGTH);
  localparam int DEPTH = CHANNELS * QUEUE_LENGTH;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] head_q [CHANNELS];
  logic [PTR_W-1:0] head_d [CHANNELS];
  logic [PTR_W-1:0] tail_q [CHANNELS];
  logic [PTR_W-1:0] tail_d [CHANNELS];
  logic [CNT_W-1:0] cnt_q  [CHANNELS];
  logic [CNT_W-1:0] cnt_d  [CHANNELS];

  logic [CHANNELS-1:0] empty_q, empty_d;
  logic [CHANNELS-1:0] full_q, full_d;
  logic [CHANNELS-1:0] thr_q, thr_d;

  logic [REGISTER_SIZE-1:0] drop_q, drop_d;
  logic [DATA_SIZE-1:0]     rdata_q;
  logic                     rvalid_q;
  logic [CH_W-1:0]          rch_q;

  logic          push_acc, pop_acc, drop;
  logic [AW-1:0] waddr, raddr;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_LENGTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Acceptance uses flags registered at the start of the cycle, so a
  // same-cycle pop never frees room for a push to a full channel.
  assign push_acc = push_valid & ~full_q[push_channel];
  assign drop     = push_valid & full_q[push_channel];
  assign pop_acc  = pop_valid & ~empty_q[pop_channel];

  assign waddr = AW'(push_channel) * AW'(QUEUE_LENGTH)
               + AW'(tail_q[push_channel]);
  assign raddr = AW'(pop_channel) * AW'(QUEUE_LENGTH)
               + AW'(head_q[pop_channel]);

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      logic inc, dec;
      inc = push_acc && (push_channel == CH_W'(i));
      dec = pop_acc && (pop_channel == CH_W'(i));
      head_d[i] = dec ? wrap_inc(head_q[i]) : head_q[i];
      tail_d[i] = inc ? wrap_inc(tail_q[i]) : tail_q[i];
      cnt_d[i]  = cnt_q[i] + CNT_W'(inc) - CNT_W'(dec);
      full_d[i]  = (cnt_d[i] == CNT_W'(QUEUE_LENGTH));
      empty_d[i] = (cnt_d[i] == '0);
      thr_d[i] = thr_q[i];
      if (high_threshold == '0)
        thr_d[i] = 1'b0;
      else if (REGISTER_SIZE'(cnt_d[i]) >= high_threshold)
        thr_d[i] = 1'b1;
      else if (REGISTER_SIZE'(cnt_d[i]) <= low_threshold)
        thr_d[i] = 1'b0;
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (drop_clear)
      drop_d = drop ? REGISTER_SIZE'(1) : '0;
    else if (drop && (drop_q != {REGISTER_SIZE{1'b1}}))
      drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset && push_acc)
      mem_q[waddr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      empty_q  <= '1;
      full_q   <= '0;
      thr_q    <= '0;
      drop_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rch_q    <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        head_q[i] <= head_d[i];
        tail_q[i] <= tail_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      empty_q  <= empty_d;
      full_q   <= full_d;
      thr_q    <= thr_d;
      drop_q   <= drop_d;
      rvalid_q <= pop_acc;
      if (pop_acc) begin
        rdata_q <= mem_q[raddr];
        rch_q   <= pop_channel;
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < CHANNELS; i++)
      occupancy[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  assign push_ready       = ~full_q[push_channel];
  assign pop_data         = rdata_q;
  assign pop_data_valid   = rvalid_q;
  assign pop_data_channel = rch_q;
  assign empty            = empty_q;
  assign full             = full_q;
  assign throttle         = thr_q;
  assign drop_count       = drop_q;

endmodule

// File: tb/tb_multi_channel_queue.sv
// Directed bench: a 4-deep and a 5-deep instance driven by the same
// stimulus; the 5-deep one is checked after its final reset.
module tb_multi_channel_queue;

  logic        clock = 0;
  logic        reset;
  logic        push_valid, pop_valid, drop_clear;
  logic [1:0]  push_channel, pop_channel;
  logic [7:0]  push_data;
  logic [31:0] high_threshold, low_threshold;

  logic        push_ready, pop_data_valid;
  logic [7:0]  pop_data;
  logic [1:0]  pop_data_channel;
  logic [3:0]  empty, full, throttle;
  logic [11:0] occupancy;
  logic [31:0] drop_count;

  logic        push_ready5, pop_data_valid5;
  logic [7:0]  pop_data5;
  logic [1:0]  pop_data_channel5;
  logic [3:0]  empty5, full5, throttle5;
  logic [15:0] occupancy5;
  logic [31:0] drop_count5;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  multi_channel_queue #(.QUEUE_LENGTH(4)) dut (
    .clock(clock), .reset(reset),
    .push_valid(push_valid), .push_channel(push_channel),
    .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_channel(pop_channel),
    .pop_data(pop_data), .pop_data_valid(pop_data_valid),
    .pop_data_channel(pop_data_channel),
    .empty(empty), .full(full), .occupancy(occupancy),
    .high_threshold(high_threshold), .low_threshold(low_threshold),
    .throttle(throttle), .drop_clear(drop_clear),
    .drop_count(drop_count)
  );

  multi_channel_queue #(.QUEUE_LENGTH(5)) dut5 (
    .clock(clock), .reset(reset),
    .push_valid(push_valid), .push_channel(push_channel),
    .push_data(push_data), .push_ready(push_ready5),
    .pop_valid(pop_valid), .pop_channel(pop_channel),
    .pop_data(pop_data5), .pop_data_valid(pop_data_valid5),
    .pop_data_channel(pop_data_channel5),
    .empty(empty5), .full(full5), .occupancy(occupancy5),
    .high_threshold(high_threshold), .low_threshold(low_threshold),
    .throttle(throttle5), .drop_clear(drop_clear),
    .drop_count(drop_count5)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] occ(input int ch);
    return 32'(occupancy[ch*3 +: 3]);
  endfunction

  function automatic logic [31:0] occ5(input int ch);
    return 32'(occupancy5[ch*4 +: 4]);
  endfunction

  task automatic push(input logic [1:0] ch, input logic [7:0] d);
    push_valid = 1; push_channel = ch; push_data = d;
  endtask

  task automatic pop(input logic [1:0] ch);
    pop_valid = 1; pop_channel = ch;
  endtask

  task automatic idle();
    push_valid = 0; pop_valid = 0; drop_clear = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; idle();
    push_channel = 0; pop_channel = 0; push_data = 0;
    high_threshold = 0; low_threshold = 0;
    tick(); tick();
    reset = 0;
    chk("rst_empty", 32'(empty), 32'hf);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_thr", 32'(throttle), 32'h0);
    chk("rst_pdv", 32'(pop_data_valid), 32'h0);
    chk("rst_pd", 32'(pop_data), 32'h0);
    chk("rst_occ", 32'(occupancy), 32'h0);
    chk("rst_drop", drop_count, 32'h0);

    // ch2 basic FIFO order
    push(2, 8'h11); tick();
    push(2, 8'h22); tick();
    push(2, 8'h33); tick();
    idle();
    chk("c2_occ3", occ(2), 3);
    chk("c2_empty0", 32'(empty[2]), 0);
    pop(2); tick();
    chk("c2_v1", 32'(pop_data_valid), 1);
    chk("c2_d1", 32'(pop_data), 32'h11);
    chk("c2_ch1", 32'(pop_data_channel), 2);
    tick();
    chk("c2_d2", 32'(pop_data), 32'h22);
    tick();
    chk("c2_d3", 32'(pop_data), 32'h33);
    chk("c2_empty", 32'(empty[2]), 1);
    idle(); tick();
    chk("c2_v0", 32'(pop_data_valid), 0);
    chk("c2_hold", 32'(pop_data), 32'h33);

    // fill ch0, push to full with simultaneous pop
    for (int k = 0; k < 4; k++) begin
      push(0, 8'(8'ha0 + k)); tick();
    end
    idle();
    chk("c0_full", 32'(full), 32'h1);
    chk("c0_rdy0", 32'(push_ready), 0);
    push_channel = 1; #1;
    chk("c1_rdy1", 32'(push_ready), 1);
    push(0, 8'hff); pop(0); tick();
    idle();
    chk("drop1", drop_count, 1);
    chk("c0_occ3", occ(0), 3);
    chk("c0_pd_a0", 32'(pop_data), 32'ha0);
    chk("c0_nfull", 32'(full[0]), 0);
    drop_clear = 1; tick(); idle();
    chk("drop_clr", drop_count, 0);
    push(0, 8'hd0); tick();
    push(0, 8'hee); tick();
    push(0, 8'hee); tick();
    chk("drop2", drop_count, 2);
    drop_clear = 1; tick();
    chk("drop_clr_hit", drop_count, 1);
    idle(); drop_clear = 1; tick(); idle();
    chk("drop_clr2", drop_count, 0);
    chk("c0_occ4", occ(0), 4);
    pop(0);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] e [4];
      e = '{8'ha1, 8'ha2, 8'ha3, 8'hd0};
      tick();
      chk("c0_drain", 32'(pop_data), 32'(e[k]));
    end
    idle();
    chk("c0_empty", 32'(empty[0]), 1);

    // throttle hysteresis on ch1
    high_threshold = 3; low_threshold = 1;
    push(1, 8'hb0); tick();
    push(1, 8'hb1); tick();
    chk("thr_c2", 32'(throttle), 0);
    push(1, 8'hb2); tick(); idle();
    chk("thr_c3", 32'(throttle), 32'h2);
    pop(1); tick();
    chk("thr_p2", 32'(throttle[1]), 1);
    chk("thr_occ2", occ(1), 2);
    tick();
    chk("thr_p1", 32'(throttle[1]), 0);
    tick(); idle();
    chk("thr_occ0", occ(1), 0);
    high_threshold = 0;
    for (int k = 4; k < 8; k++) begin
      push(1, 8'(8'hb0 + k)); tick();
    end
    idle();
    chk("thr0_full", 32'(full[1]), 1);
    chk("thr0_off", 32'(throttle), 0);
    pop(1);
    for (int k = 4; k < 8; k++) begin
      tick();
      chk("c1_drain", 32'(pop_data), 32'(8'hb0 + k));
    end

    // empty pop ignored, then independent channels
    tick(); idle();
    chk("epop_v0", 32'(pop_data_valid), 0);
    chk("epop_hold", 32'(pop_data), 32'hb7);
    chk("epop_occ", occ(1), 0);
    push(1, 8'h5a); tick();
    push(0, 8'h61); pop(1); tick(); idle();
    chk("ind_pd", 32'(pop_data), 32'h5a);
    chk("ind_ch", 32'(pop_data_channel), 1);
    chk("ind_occ0", occ(0), 1);
    chk("ind_occ1", occ(1), 0);
    pop(0); tick(); idle();
    chk("ind_pd0", 32'(pop_data), 32'h61);
    chk("ind_ch0", 32'(pop_data_channel), 0);

    // reset right after an accepted pop
    push(0, 8'h77); tick();
    push(2, 8'h88); tick(); idle();
    pop(0); tick();
    chk("pre_rst_v", 32'(pop_data_valid), 1);
    reset = 1; tick();
    chk("rs_v0", 32'(pop_data_valid), 0);
    chk("rs_empty", 32'(empty), 32'hf);
    chk("rs_occ", 32'(occupancy), 0);
    chk("rs_drop", drop_count, 0);
    chk("rs_pd", 32'(pop_data), 0);
    reset = 0; idle(); tick();

    // same-channel push+pop across pointer wrap, depth 4 and 5
    push(3, 8'hc0); tick();
    push(3, 8'hc1); tick();
    for (int k = 0; k < 6; k++) begin
      push(3, 8'(8'hc2 + k)); pop(3); tick();
      chk("wr4_pd", 32'(pop_data), 32'(8'hc0 + k));
      chk("wr4_occ", occ(3), 2);
      chk("wr5_pd", 32'(pop_data5), 32'(8'hc0 + k));
      chk("wr5_occ", occ5(3), 2);
    end
    idle();
    chk("wr_full", 32'(full | full5), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
